// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared op codes, FSM states, LFSR seed and helpers for enemy_field
// Purpose: common definitions imported by enemy_field.
// Contents: state_e (S_WAIT/S_ERASE/S_MOVE/S_DRAW), OP_DRAW/OP_ERASE, colours,
//           LFSR_SEED, lfsr_next(), lane_x(), init_x().
package game_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ERASE = 2'd1,
    S_MOVE  = 2'd2,
    S_DRAW  = 2'd3
  } state_e;

  localparam logic [1:0] OP_DRAW    = 2'b00;
  localparam logic [1:0] OP_ERASE   = 2'b01;
  localparam logic [2:0] COLOUR_ON  = 3'b111;
  localparam logic [2:0] COLOUR_OFF = 3'b000;
  localparam logic [7:0] LFSR_SEED  = 8'h5A;

  // Fibonacci form of x^8+x^6+x^5+x^4+1. The map is invertible and fixes
  // zero, so a non-zero seed can never reach the all-zero state.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Lane 0..15 maps to x = 2..152 in steps of 10.
  function automatic logic [7:0] lane_x(input logic [3:0] lane);
    return {4'd0, lane} * 8'd10 + 8'd2;
  endfunction

  // Power-on spread: slot i starts in lane (i*7) mod 16.
  function automatic logic [7:0] init_x(input int i);
    logic [3:0] lane;
    lane = 4'((i * 7) % 16);
    return lane_x(lane);
  endfunction

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - free-running divider producing a one-cycle tick every DIV cycles
// Purpose: frame / move timebase.
// Ports: clk, reset (async, active-high), tick (high for one cycle every DIV cycles).
module tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/enemy_field.sv
// rtl/enemy_field.sv - enemy slot field: per-frame erase / move / draw sequencer
// Purpose: keeps x/y of N_SLOTS enemies, moves them on move ticks, respawns on
//          hit or bottom edge, and sequences sprite erase/draw handshakes.
// Ports: clk, reset (async, active-high), active_cnt (live slot request),
//        flying_rate (rows per move), hit (per-slot destroy pulses),
//        draw_done (datapath ack); draw_req, op, x_out, y_out, colour (sprite
//        command), edge_hit and kill (one-cycle event pulses).
module enemy_field
  import game_pkg::*;
#(
  parameter int N_SLOTS   = 10,
  parameter int Y_MAX     = 120,
  parameter int FRAME_DIV = 1666667,
  parameter int MOVE_DIV  = 12500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         active_cnt,
  input  logic [1:0]         flying_rate,
  input  logic [N_SLOTS-1:0] hit,
  input  logic               draw_done,
  output logic               draw_req,
  output logic [1:0]         op,
  output logic [7:0]         x_out,
  output logic [6:0]         y_out,
  output logic [2:0]         colour,
  output logic               edge_hit,
  output logic               kill
);

  logic frame_tick, move_tick;

  tick_div #(.DIV(FRAME_DIV)) u_frame_div (.clk(clk), .reset(reset), .tick(frame_tick));
  tick_div #(.DIV(MOVE_DIV))  u_move_div  (.clk(clk), .reset(reset), .tick(move_tick));

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               req_q, req_d;
  logic [7:0]         x_q [N_SLOTS];
  logic [7:0]         x_d [N_SLOTS];
  logic [6:0]         y_q [N_SLOTS];
  logic [6:0]         y_d [N_SLOTS];
  logic [7:0]         lfsr_q, lfsr_d;
  logic [N_SLOTS-1:0] hit_pend_q, hit_pend_d;
  logic               move_pend_q, move_pend_d;
  logic               kill_q, kill_d;
  logic               edge_q, edge_d;

  logic [4:0] live_cnt;
  logic       cur_live;
  logic       last_idx;

  assign live_cnt = (active_cnt > 5'(N_SLOTS)) ? 5'(N_SLOTS) : active_cnt;
  assign cur_live = ({1'b0, idx_q} < live_cnt);
  assign last_idx = (idx_q == 4'(N_SLOTS - 1));

  assign draw_req = req_q;
  assign op       = (state_q == S_ERASE) ? OP_ERASE : OP_DRAW;
  assign x_out    = x_q[idx_q];
  assign y_out    = y_q[idx_q];
  assign colour   = (state_q == S_DRAW && cur_live) ? COLOUR_ON : COLOUR_OFF;
  assign edge_hit = edge_q;
  assign kill     = kill_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_d       = req_q;
    x_d         = x_q;
    y_d         = y_q;
    lfsr_d      = lfsr_q;
    hit_pend_d  = hit_pend_q | hit;
    move_pend_d = move_pend_q | move_tick;
    kill_d      = 1'b0;
    edge_d      = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (frame_tick) begin
          state_d = S_ERASE;
          idx_d   = '0;
        end
      end

      S_ERASE, S_DRAW: begin
        // Dead slots cost one cycle; live slots raise req one cycle after the
        // index settles and advance on the same edge that drops req.
        if (!cur_live || (req_q && draw_done)) begin
          req_d = 1'b0;
          if (last_idx) begin
            state_d = (state_q == S_ERASE) ? S_MOVE : S_WAIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (!req_q) begin
          req_d = 1'b1;
        end
      end

      S_MOVE: begin
        // Consume the pending vectors; events arriving this very cycle are
        // kept for the next frame.
        hit_pend_d  = hit;
        move_pend_d = move_tick;
        for (int i = 0; i < N_SLOTS; i++) begin
          if (5'(i) < live_cnt) begin
            if (hit_pend_q[i]) begin
              y_d[i] = '0;
              x_d[i] = lane_x(lfsr_d[3:0]);
              lfsr_d = lfsr_next(lfsr_d);
              kill_d = 1'b1;
            end else if (move_pend_q) begin
              if (({1'b0, y_q[i]} + 8'(flying_rate)) >= 8'(Y_MAX)) begin
                y_d[i] = '0;
                x_d[i] = lane_x(lfsr_d[3:0]);
                lfsr_d = lfsr_next(lfsr_d);
                edge_d = 1'b1;
              end else begin
                y_d[i] = y_q[i] + 7'(flying_rate);
              end
            end
          end
        end
        state_d = S_DRAW;
        idx_d   = '0;
      end

      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT;
      idx_q       <= '0;
      req_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      hit_pend_q  <= '0;
      move_pend_q <= 1'b0;
      kill_q      <= 1'b0;
      edge_q      <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i] <= init_x(i);
        y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_q       <= req_d;
      lfsr_q      <= lfsr_d;
      hit_pend_q  <= hit_pend_d;
      move_pend_q <= move_pend_d;
      kill_q      <= kill_d;
      edge_q      <= edge_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

endmodule

// File: tb/tb_enemy_field.sv
// tb/tb_enemy_field.sv - scoreboard bench for enemy_field with a frame-level reference model
module tb_enemy_field;

  localparam int N  = 10;
  localparam int YM = 120;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   active_cnt = '0;
  logic [1:0]   flying_rate = '0;
  logic [N-1:0] hit = '0;
  logic         draw_done = 1'b0;
  logic         draw_req;
  logic [1:0]   op;
  logic [7:0]   x_out;
  logic [6:0]   y_out;
  logic [2:0]   colour;
  logic         edge_hit;
  logic         kill;

  enemy_field #(
    .N_SLOTS(N), .Y_MAX(YM), .FRAME_DIV(4), .MOVE_DIV(3)
  ) dut (
    .clk(clk), .reset(reset), .active_cnt(active_cnt), .flying_rate(flying_rate),
    .hit(hit), .draw_done(draw_done), .draw_req(draw_req), .op(op),
    .x_out(x_out), .y_out(y_out), .colour(colour), .edge_hit(edge_hit), .kill(kill)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_move;
    int op;
    int x;
    int y;
    int col;
    bit kill;
    bit edge_p;
  } exp_t;

  exp_t expq[$];
  int   compared = 0;
  int   mismatched = 0;

  // Reference model: per-slot position, pending hits, LFSR, frame counters.
  int mx[N];
  int my[N];
  bit mpend[N];
  int mlfsr;
  int mact;
  int mrate;
  bit gen_draw_next;
  int frames_done;

  function automatic int lfsr_step(input int s);
    return ((s << 1) & 8'hFF) | ($countones(s & 8'hB8) & 1);
  endfunction

  task automatic push_hs(input int o, input int x, input int y, input int c);
    exp_t e;
    e.is_move = 0; e.op = o; e.x = x; e.y = y; e.col = c; e.kill = 0; e.edge_p = 0;
    expq.push_back(e);
  endtask

  task automatic gen_erase();
    for (int i = 0; i < mact; i++) push_hs(1, mx[i], my[i], 0);
  endtask

  task automatic respawn(input int i);
    my[i] = 0;
    mx[i] = (mlfsr % 16) * 10 + 2;
    mlfsr = lfsr_step(mlfsr);
  endtask

  // One move per frame is always available (move ticks outpace frames).
  task automatic gen_move_draw();
    bit k, ed;
    exp_t e;
    k = 0; ed = 0;
    for (int i = 0; i < mact; i++) begin
      if (mpend[i]) begin
        respawn(i); k = 1;
      end else if (my[i] + mrate >= YM) begin
        respawn(i); ed = 1;
      end else begin
        my[i] = my[i] + mrate;
      end
    end
    for (int i = 0; i < N; i++) mpend[i] = 0;
    if (k || ed) begin
      e.is_move = 1; e.op = 0; e.x = 0; e.y = 0; e.col = 0; e.kill = k; e.edge_p = ed;
      expq.push_back(e);
    end
    for (int i = 0; i < mact; i++) push_hs(0, mx[i], my[i], 7);
  endtask

  task automatic model_reset(input int act, input int rate);
    mact  = (act > N) ? N : act;
    mrate = rate;
    mlfsr = 8'h5A;
    for (int i = 0; i < N; i++) begin
      mx[i] = ((i * 7) % 16) * 10 + 2;
      my[i] = 0;
      mpend[i] = 0;
    end
    expq.delete();
    gen_erase();
    gen_draw_next = 1;
  endtask

  task automatic model_hit(input int s);
    if (s < mact) mpend[s] = 1;
  endtask

  task automatic chk(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_event(input exp_t g, input string what);
    exp_t e;
    compared++;
    if (expq.size() == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected event move=%0d op=%0d x=%0d y=%0d col=%0d kill=%0d edge=%0d",
               what, g.is_move, g.op, g.x, g.y, g.col, g.kill, g.edge_p);
      return;
    end
    e = expq.pop_front();
    if (e.is_move != g.is_move || e.op != g.op || e.x != g.x || e.y != g.y ||
        e.col != g.col || e.kill != g.kill || e.edge_p != g.edge_p) begin
      mismatched++;
      $display("FAIL %s: got move=%0d op=%0d x=%0d y=%0d col=%0d kill=%0d edge=%0d required move=%0d op=%0d x=%0d y=%0d col=%0d kill=%0d edge=%0d",
               what, g.is_move, g.op, g.x, g.y, g.col, g.kill, g.edge_p,
               e.is_move, e.op, e.x, e.y, e.col, e.kill, e.edge_p);
    end
    if (expq.size() == 0) begin
      if (gen_draw_next) begin
        gen_move_draw();
        gen_draw_next = 0;
      end else begin
        frames_done++;
        gen_erase();
        gen_draw_next = 1;
      end
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, after the driver.
  bit req_seen = 0;
  int cap_op, cap_x, cap_y, cap_col;

  always begin
    exp_t g;
    @(negedge clk);
    #2;
    if (reset) begin
      req_seen = 0;
    end else begin
      if (draw_req && !req_seen) begin
        req_seen = 1;
        cap_op = int'(op); cap_x = int'(x_out); cap_y = int'(y_out); cap_col = int'(colour);
      end
      if (draw_req && draw_done) begin
        compared++;
        if (cap_op != int'(op) || cap_x != int'(x_out) || cap_y != int'(y_out) || cap_col != int'(colour)) begin
          mismatched++;
          $display("FAIL stable: got op=%0d x=%0d y=%0d col=%0d required op=%0d x=%0d y=%0d col=%0d",
                   op, x_out, y_out, colour, cap_op, cap_x, cap_y, cap_col);
        end
        g.is_move = 0; g.op = int'(op); g.x = int'(x_out); g.y = int'(y_out);
        g.col = int'(colour); g.kill = 0; g.edge_p = 0;
        check_event(g, "handshake");
        req_seen = 0;
      end
      if (kill || edge_hit) begin
        g.is_move = 1; g.op = 0; g.x = 0; g.y = 0; g.col = 0; g.kill = kill; g.edge_p = edge_hit;
        check_event(g, "move_pulse");
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_draw_req"}, int'(draw_req), 0);
    chk({tag, "_op"},       int'(op), 0);
    chk({tag, "_colour"},   int'(colour), 0);
    chk({tag, "_x_out"},    int'(x_out), 2);
    chk({tag, "_y_out"},    int'(y_out), 0);
    chk({tag, "_edge_hit"}, int'(edge_hit), 0);
    chk({tag, "_kill"},     int'(kill), 0);
  endtask

  // Driver: datapath responder plus hit injection; ends each segment with a
  // reset landing while draw_req is high.
  task automatic run_segment(input int act, input int rate, input int frames);
    int budget, delay, erase_seen, s;
    bit smove_hit;
    budget = 0; delay = -1; erase_seen = 0; smove_hit = 0;
    active_cnt  = 5'(act);
    flying_rate = 2'(rate);
    model_reset(act, rate);
    frames_done = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      hit = '0;
      if (smove_hit) begin
        s = $urandom_range(0, N - 1);
        hit[s] = 1'b1;
        model_hit(s);
        smove_hit = 0;
      end
      if (draw_done) begin
        draw_done = 1'b0;
        delay = -1;
      end else if (draw_req) begin
        if (frames_done >= frames) break;
        if (delay < 0) begin
          delay = $urandom_range(0, 3);
          if (op == 2'b01) erase_seen++;
          else erase_seen = 0;
          if ($urandom_range(0, 3) == 0) begin
            s = $urandom_range(0, N - 1);
            hit[s] = 1'b1;
            model_hit(s);
          end
        end
        if (delay == 0) begin
          draw_done = 1'b1;
          // Hit lands exactly in the S_MOVE cycle after the last erase.
          if (op == 2'b01 && erase_seen == N && mact == N && $urandom_range(0, 1) == 1)
            smove_hit = 1;
        end else begin
          delay--;
        end
      end
      budget++;
      if (budget > 20000) begin
        compared++;
        mismatched++;
        $display("FAIL timeout: got %0d frames required %0d", frames_done, frames);
        break;
      end
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    draw_done = 1'b0;
    hit = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    run_segment(3, 1, 6);
    run_segment(20, 3, 50);
    run_segment(10, 2, 45);
    run_segment(7, 0, 8);
    for (int k = 0; k < 3; k++)
      run_segment($urandom_range(1, 20), $urandom_range(1, 3), 45);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
